// File: rtl/rx_core.sv
// UART receive core: 16x oversampled deserialiser with majority-vote sampling,
// parity/stop checking and an active-low FIFO write strobe.
module rx_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_OverSampleSig_i,
    input  logic       Rx_i,
    input  logic       p_ParityEnable_i,
    input  logic       ParityMethod_i,
    input  logic       p_BigEnd_i,
    output logic [7:0] data_o,
    output logic       n_we_o,
    input  logic       p_full_i,
    output logic       p_ParityErr_o,
    output logic       p_FrameErr_o,
    output logic       p_Overrun_o
);

    localparam int unsigned TICK_W    = 4;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned DATA_W    = 8;

    localparam logic [TICK_W-1:0]    SAMPLE_A = TICK_W'(6);
    localparam logic [TICK_W-1:0]    SAMPLE_B = TICK_W'(7);
    localparam logic [TICK_W-1:0]    SAMPLE_C = TICK_W'(8);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_BREAK,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rxs_q, rxs_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic                   s6_q, s6_d;
    logic                   s7_q, s7_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   big_end_q, big_end_d;
    logic                   par_err_pend_q, par_err_pend_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   n_we_q, n_we_d;
    logic                   par_err_q, par_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    logic [TICK_W-1:0]      tick_nxt;
    logic                   decide;
    logic                   maj;

    assign tick_nxt = tick_q + TICK_W'(1);
    assign decide   = p_OverSampleSig_i && (tick_nxt == SAMPLE_C);
    // third vote is the live sample taken at the decision tick
    assign maj      = (s6_q & s7_q) | (s6_q & rxs_q) | (s7_q & rxs_q);

    always_comb begin
        rx_meta_d      = Rx_i;
        rxs_d          = rx_meta_q;
        state_d        = state_q;
        tick_d         = tick_q;
        bit_d          = bit_q;
        s6_d           = s6_q;
        s7_d           = s7_q;
        shift_d        = shift_q;
        par_en_d       = par_en_q;
        par_odd_d      = par_odd_q;
        big_end_d      = big_end_q;
        par_err_pend_d = par_err_pend_q;
        data_d         = data_q;
        n_we_d         = 1'b1;
        par_err_d      = par_err_q;
        frame_err_d    = frame_err_q;
        overrun_d      = overrun_q;

        if (p_OverSampleSig_i) begin
            tick_d = tick_nxt;
            if (tick_nxt == SAMPLE_A) s6_d = rxs_q;
            if (tick_nxt == SAMPLE_B) s7_d = rxs_q;
        end

        case (state_q)
            ST_BREAK: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!rxs_q) begin
                    tick_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (decide) begin
                    if (maj) begin
                        state_d = ST_IDLE;
                    end else begin
                        par_en_d  = p_ParityEnable_i;
                        par_odd_d = ParityMethod_i;
                        big_end_d = p_BigEnd_i;
                        bit_d     = '0;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d = big_end_q ? {shift_q[DATA_W-2:0], maj}
                                        : {maj, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + BIT_CNT_W'(1);
                    if (bit_q == LAST_BIT) state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    par_err_pend_d = ((^shift_q) ^ maj) != par_odd_q;
                    state_d        = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    frame_err_d = ~maj;
                    par_err_d   = par_en_q & par_err_pend_q;
                    overrun_d   = 1'b0;
                    if (maj) begin
                        state_d = ST_IDLE;
                        if (p_full_i) begin
                            overrun_d = 1'b1;
                        end else begin
                            n_we_d = 1'b0;
                            data_d = shift_q;
                        end
                    end else begin
                        // held-low line must not retrigger a frame
                        state_d = ST_BREAK;
                    end
                end
            end
            default: state_d = ST_BREAK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_BREAK;
            rx_meta_q      <= 1'b1;
            rxs_q          <= 1'b1;
            tick_q         <= '0;
            bit_q          <= '0;
            s6_q           <= 1'b1;
            s7_q           <= 1'b1;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            big_end_q      <= 1'b0;
            par_err_pend_q <= 1'b0;
            data_q         <= '0;
            n_we_q         <= 1'b1;
            par_err_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_meta_q      <= rx_meta_d;
            rxs_q          <= rxs_d;
            tick_q         <= tick_d;
            bit_q          <= bit_d;
            s6_q           <= s6_d;
            s7_q           <= s7_d;
            shift_q        <= shift_d;
            par_en_q       <= par_en_d;
            par_odd_q      <= par_odd_d;
            big_end_q      <= big_end_d;
            par_err_pend_q <= par_err_pend_d;
            data_q         <= data_d;
            n_we_q         <= n_we_d;
            par_err_q      <= par_err_d;
            frame_err_q    <= frame_err_d;
            overrun_q      <= overrun_d;
        end
    end

    assign data_o        = data_q;
    assign n_we_o        = n_we_q;
    assign p_ParityErr_o = par_err_q;
    assign p_FrameErr_o  = frame_err_q;
    assign p_Overrun_o   = overrun_q;

endmodule

// File: tb/tb_rx_core.sv
// Randomised scoreboard bench for rx_core: frames are driven tick-aligned on the
// serial line, expected writes are queued and a monitor checks each write strobe.
module tb_rx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os = 1'b0;
    logic       rx = 1'b1;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       big_end = 1'b0;
    logic       full = 1'b0;
    logic [7:0] data_o;
    logic       n_we_o;
    logic       perr_o;
    logic       ferr_o;
    logic       ovr_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;
    exp_t exp_q[$];

    // reference-model view of the flags after the last completed frame
    logic m_perr = 1'b0;
    logic m_ferr = 1'b0;
    logic m_ovr  = 1'b0;

    logic [1:0] div = 2'd0;
    logic       prev_we_low = 1'b0;

    rx_core dut (
        .clk               (clk),
        .rst               (rst),
        .p_OverSampleSig_i (os),
        .Rx_i              (rx),
        .p_ParityEnable_i  (par_en),
        .ParityMethod_i    (par_odd),
        .p_BigEnd_i        (big_end),
        .data_o            (data_o),
        .n_we_o            (n_we_o),
        .p_full_i          (full),
        .p_ParityErr_o     (perr_o),
        .p_FrameErr_o      (ferr_o),
        .p_Overrun_o       (ovr_o)
    );

    always #5 clk = ~clk;

    // 16x tick: one clk pulse every 4 clks
    always @(posedge clk) begin
        div <= div + 2'd1;
        os  <= (div == 2'd3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write strobe must match the head of the queue
    always @(negedge clk) begin
        if (!rst) begin
            if (n_we_o === 1'b0) begin
                check("n_we_width", 32'(prev_we_low), 32'd0);
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data_o", 32'(data_o), 32'(e.data));
                    check("perr_on_write", 32'(perr_o), 32'(e.perr));
                    check("ferr_on_write", 32'(ferr_o), 32'd0);
                    check("ovr_on_write", 32'(ovr_o), 32'd0);
                end
            end
            prev_we_low = (n_we_o === 1'b0);
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (os !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_perr"}, 32'(perr_o), 32'(m_perr));
        check({tag, "_ferr"}, 32'(ferr_o), 32'(m_ferr));
        check({tag, "_ovr"},  32'(ovr_o),  32'(m_ovr));
    endtask

    // glitch_bit: data bit whose middle sample is inverted; rst_bit: data bit during which reset hits
    task automatic send_frame(input logic [7:0] d, input logic be, input logic pe, input logic odd,
                              input logic pbit, input logic stopb, input int glitch_bit,
                              input logic scramble, input int rst_bit);
        logic b;
        logic e_perr;
        e_perr = pe && ((($countones(d) + int'(pbit)) % 2) != int'(odd));
        par_en  = pe;
        par_odd = odd;
        big_end = be;
        rx = 1'b0;
        wait_ticks(16);
        if (scramble) begin
            par_en  = 1'($urandom);
            par_odd = 1'($urandom);
            big_end = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            b  = be ? d[7-i] : d[i];
            rx = b;
            if (rst_bit == i) begin
                wait_ticks(4);
                rst = 1'b1;
                #1;
                check("rst_data", 32'(data_o), 32'd0);
                check("rst_n_we", 32'(n_we_o), 32'd1);
                check("rst_perr", 32'(perr_o), 32'd0);
                check("rst_ferr", 32'(ferr_o), 32'd0);
                check("rst_ovr",  32'(ovr_o),  32'd0);
                rx = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                m_perr = 1'b0;
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
                wait_ticks(8);
                return;
            end
            if (glitch_bit == i) begin
                wait_ticks(6);
                rx = ~b;
                wait_ticks(1);
                rx = b;
                wait_ticks(9);
            end else begin
                wait_ticks(16);
            end
        end
        if (pe) begin
            rx = pbit;
            wait_ticks(16);
        end
        if (stopb && !full) exp_q.push_back('{data: d, perr: e_perr});
        m_perr = e_perr;
        m_ferr = !stopb;
        m_ovr  = stopb && full;
        rx = stopb;
        wait_ticks(16);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check_flags("frame");
        if (stopb) wait_ticks(3);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_n_we", 32'(n_we_o), 32'd1);
        check_flags("reset");
        rst = 1'b0;
        wait_ticks(4);

        // basic LSB-first frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);
        // MSB-first, odd parity: good then bad parity bit
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, -1);

        // framing error, line held low for 40 bit times
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1);
        wait_ticks(40 * 16);
        check_flags("break_hold");
        rx = 1'b1;
        wait_ticks(16);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);

        // FIFO full then free
        full = 1'b1;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);
        full = 1'b0;
        send_frame(8'h6E, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, -1);

        // 3-tick low glitch on idle line: false start, flags unchanged
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(24);
        check_flags("false_start");

        // 1-tick glitch inside a data bit, with config changing mid-frame
        send_frame(8'hC9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1, -1);

        // parity error frame leaves nonzero state, then reset mid-frame, then recovery
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 4);
        check_flags("post_reset");
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);

        // randomised frames
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            logic       be, pe, odd, pbit;
            d    = 8'($urandom);
            be   = 1'($urandom);
            pe   = 1'($urandom);
            odd  = 1'($urandom);
            pbit = 1'($urandom);
            full = ($urandom_range(0, 3) == 0);
            send_frame(d, be, pe, odd, pbit, 1'b1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1,
                       1'b1, -1);
        end
        full = 1'b0;

        wait_ticks(16);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_core.md
# rx_core

UART receive path, the counterpart of the transmit core: deserialises the line driven by a remote transmitter, using a 16x oversampling tick from the baud-rate module. It checks the start, parity and stop bits, and pushes each good byte into the receive FIFO through that FIFO's active-low write port. Frame configuration is the same as the transmit side (parity enable, parity method, bit order), so a Tx/Rx pair loops back cleanly.

## Interface
Parameters:
- none; frame is fixed at 1 start, 8 data, optional parity, 1 stop.

Ports:
- clk  in  1  system clock, ≥40 MHz.
- rst  in  1  asynchronous, active-high reset; release synchronous to clk.
- p_OverSampleSig_i  in  1  one-clk pulse at 16x baud rate.
- Rx_i  in  1  serial line, asynchronous to clk, idle high.
- p_ParityEnable_i  in  1  1 = parity bit present.
- ParityMethod_i  in  1  0 = even, 1 = odd.
- p_BigEnd_i  in  1  1 = MSB first; 0 = LSB first.
- data_o  out  8  received byte, valid while n_we_o is low.
- n_we_o  out  1  FIFO write strobe, active low, one clk wide.
- p_full_i  in  1  receive FIFO full.
- p_ParityErr_o  out  1  parity mismatch on the last completed frame.
- p_FrameErr_o  out  1  stop bit sampled low on the last completed frame.
- p_Overrun_o  out  1  last good frame was dropped because the FIFO was full.

## Operation
- Rx_i passes through a 2-flop synchroniser. Both flops reset to 1. All logic uses the synchronised value rxs.
- A 4-bit tick counter advances on each p_OverSampleSig_i and wraps 15 to 0. A bit period is 16 ticks.
- Each bit is sampled at ticks 6, 7 and 8 of its period. The bit value is the majority of the 3 samples, decided at tick 8.
- States and transitions:
  - BREAK: reset state. Go to IDLE on the first clk where rxs = 1.
  - IDLE: on rxs = 0, clear the tick counter and go to START.
  - START: at the tick-8 decision, a majority of 1 is a false start and returns to IDLE. Otherwise latch p_ParityEnable_i, ParityMethod_i and p_BigEnd_i for the whole frame, clear the bit counter, and go to DATA.
  - DATA: shift in 8 bits.
    - LSB first: shift right, new bit enters bit 7.
    - MSB first: shift left, new bit enters bit 0.
    - After the 8th bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: compute p = XOR of the 8 data bits XOR the received parity bit. Parity error = (p ≠ 0) for even, (p ≠ 1) for odd. Go to STOP.
  - STOP: at the tick-8 decision, update the error flags and write logic (below).
    - Stop bit 1: go to IDLE.
    - Stop bit 0: go to BREAK, so a held-low line does not retrigger.
- Flag and write update at the end of each frame:
  - p_FrameErr_o = (stop bit == 0).
  - p_ParityErr_o = parity error; held at 0 when parity is disabled.
  - Write attempt happens when the stop bit is 1, regardless of parity error.
    - If p_full_i = 0: assert n_we_o and set p_Overrun_o = 0.
    - If p_full_i = 1: no write and set p_Overrun_o = 1.
  - Frame error: no write and p_Overrun_o = 0.
  - All three flags hold until the next completed frame. A false start does not change them.
- Config inputs may change at any time. Only the values latched in START affect a frame.

## Timing
- Reset values:
  - data_o = 0x00, n_we_o = 1, all error flags = 0.
  - State = BREAK; synchroniser = 1; counters = 0.
- Synchroniser adds 2 clk of delay from Rx_i to rxs.
- n_we_o goes low in the clk after the stop-bit decision, for exactly 1 clk. data_o and the flags are registered in the same clk as n_we_o and stay stable afterwards.
- Frame decision falls 8 + 16·(9 + P) ticks after the falling edge is detected, where P = parity enable. That is 152 ticks without parity and 168 ticks with parity.
- The next start bit is accepted from IDLE in the clk after the STOP decision. This tolerates a stop bit shortened to 9 ticks.
- Asynchronous reset mid-frame: return to BREAK immediately, abort the frame, no write, no flag update.

## Test plan
- 0xA5, LSB first, no parity, 16 ticks/bit, FIFO not full -> exactly one n_we_o low pulse with data_o = 0xA5; all flags 0.
- 0x3C, MSB first, odd parity, parity bit 1 -> data_o = 0x3C, p_ParityErr_o = 0. Same frame with parity bit 0 -> write occurs and p_ParityErr_o = 1.
- 0x55 with stop bit 0, then line held low for 40 bit times -> no write, p_FrameErr_o = 1, single frame only. After the line returns high, a following 0x12 frame is received with p_FrameErr_o = 0.
- p_full_i = 1 during a 0xFF frame -> n_we_o stays 1, p_Overrun_o = 1. Next frame with p_full_i = 0 -> write and p_Overrun_o = 0.
- 3-tick low glitch on idle line -> no state change beyond START and back to IDLE, no write, flags unchanged. A 1-tick glitch inside a data bit is rejected by the majority vote, and the byte is correct.
- Assert rst during bit 4 of a frame -> outputs return to reset values immediately, no write. The next complete frame, 0x81, is received correctly.
